// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 32x128 SRAM request controller.
// Optional write acknowledgements are enabled with SRAM_CTRL_WACK_EN.
package sram_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 7;
  localparam int RSP_DEPTH  = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_entry_t;

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Response FIFO: first-word output, same-cycle push/pop, occupancy count.
module sram_ctrl_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The controller reserves a slot before issuing, so a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/sram_32x128_ctrl.sv
// Valid/ready front end for the 32x128 single-port SRAM macro with zero-fill after reset.
// Define SRAM_CTRL_WACK_EN to return one ordered response (rsp_write=1) per accepted write.
module sram_32x128_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int RSP_DEPTH  = sram_ctrl_pkg::RSP_DEPTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_write,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output state_e                dbg_state
);

`ifdef SRAM_CTRL_WACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int CW        = $clog2(RSP_DEPTH+1);

  // Handshake: a request transfers on a posedge where req_valid && req_ready; a response
  // transfers on a posedge where rsp_valid && rsp_ready. Neither ready depends on its valid.

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d, addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  init_done_q, init_done_d, csb0_q, csb0_d, web0_q, web0_d;
  logic                  tag1_q, tag1_d, tag1_w_q, tag1_w_d, tag2_q, tag2_w_q;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   push_data, head;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  accept, fifo_valid;
  int                    occ;

  // Every response-producing access holds a slot from issue until it is popped.
  always_comb begin
    occ = int'(fifo_count) + int'(tag1_q) + int'(tag2_q);
  end

  assign req_ready = (state_q == RUN) && (occ < RSP_DEPTH);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    tag1_d      = 1'b0;
    tag1_w_d    = 1'b0;
    case (state_q)
      INIT: begin
        csb0_d     = 1'b0;
        web0_d     = 1'b0;
        addr0_d    = init_cnt_q;
        din0_d     = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_WIDTH'(RAM_DEPTH-1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          csb0_d   = 1'b0;
          web0_d   = ~req_we;
          addr0_d  = req_addr;
          tag1_d   = !req_we || WACK;
          tag1_w_d = req_we && WACK;
          if (req_we) din0_d = req_wdata;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      tag1_q      <= 1'b0;
      tag1_w_q    <= 1'b0;
      tag2_q      <= 1'b0;
      tag2_w_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      tag1_q      <= tag1_d;
      tag1_w_q    <= tag1_w_d;
      tag2_q      <= tag1_q;
      tag2_w_q    <= tag1_w_q;
    end
  end

  // tag2 marks the cycle in which dout0 holds the macro's answer for the tagged access.
  assign cap_data  = tag2_w_q ? '0 : dout0;
  assign push_data = {tag2_w_q, cap_data};

  sram_ctrl_rsp_fifo #(
    .WIDTH (DATA_WIDTH+1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk0),
    .rst_i   (rst0),
    .push_i  (tag2_q),
    .data_i  (push_data),
    .pop_i   (rsp_ready),
    .valid_o (fifo_valid),
    .data_o  (head),
    .count_o (fifo_count)
  );

  assign rsp_valid = fifo_valid;
  assign rsp_rdata = fifo_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rsp_write = WACK && fifo_valid && head[DATA_WIDTH];
  assign init_done = init_done_q;
  assign csb0      = csb0_q;
  assign web0      = web0_q;
  assign addr0     = addr0_q;
  assign din0      = din0_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_32x128_ctrl.sv
// Directed bench for sram_32x128_ctrl with a behavioural model of the 32x128 macro.
module tb_sram_32x128_ctrl;
  import sram_ctrl_pkg::*;

`ifdef SRAM_CTRL_WACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic        clk0 = 1'b0, rst0 = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_write, init_done, csb0, web0;
  logic [31:0] rsp_rdata, din0, dout0;
  logic [6:0]  addr0;
  state_e      dbg_state;

  int n_cmp = 0, n_err = 0, cyc_cnt = 0;
  logic [32:0] exp_q[$];

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sram_32x128_ctrl dut (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .init_done(init_done), .csb0(csb0), .web0(web0),
    .addr0(addr0), .din0(din0), .dout0(dout0), .dbg_state(dbg_state)
  );

  // ---------------- macro model: samples on posedge, acts on following negedge ----------------
  logic [31:0] mem [128];
  logic        m_csb = 1'b1, m_web = 1'b1;
  logic [6:0]  m_addr = '0;
  logic [31:0] m_din = '0;

  initial begin
    dout0 = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA5A5_0000 | i;
  end

  always @(posedge clk0) begin
    m_csb  <= csb0;
    m_web  <= web0;
    m_addr <= addr0;
    m_din  <= din0;
  end

  always @(negedge clk0) begin
    if (!m_csb) begin
      if (!m_web) mem[m_addr] = m_din;
      else        dout0 = mem[m_addr];
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk0) begin
    logic [32:0] e;
    if (!rst0 && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got write=%b data=%h, required no response", rsp_write, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_write, rsp_rdata} !== e) begin
          n_err++;
          $display("FAIL rsp_data: got write=%b data=%h, required write=%b data=%h",
                   rsp_write, rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [6:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data);
    int g = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk0);
    while (!req_ready && g < 200) begin @(negedge clk0); g++; end
    if (g >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: req_ready=0 after 200 cycles, required 1 (addr %h)", a);
    end else if (!we) exp_q.push_back({1'b0, exp_data});
    else if (WACK)    exp_q.push_back({1'b1, 32'h0});
    @(posedge clk0); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin @(negedge clk0); g++; end
    @(posedge clk0); @(negedge clk0);
    n_cmp++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain: pending=%0d rsp_valid=%b, required 0 and 0", exp_q.size(), rsp_valid);
    end
    @(posedge clk0); #1;
  endtask

  task automatic wait_init();
    int cyc = 0;
    while (!init_done && cyc < 300) begin
      @(posedge clk0); #1; cyc++;
      if (cyc == 1) begin
        n_cmp++;
        if ({csb0, web0, addr0, din0} !== {1'b0, 1'b0, 7'h00, 32'h0}) begin
          n_err++;
          $display("FAIL init_first: csb0=%b web0=%b addr0=%h din0=%h, required 0 0 00 0",
                   csb0, web0, addr0, din0);
        end
      end
      if (cyc == 64) begin
        n_cmp++;
        if (req_ready !== 1'b0 || addr0 !== 7'd63) begin
          n_err++;
          $display("FAIL init_mid: req_ready=%b addr0=%0d, required 0 and 63", req_ready, addr0);
        end
      end
    end
    n_cmp++;
    if (cyc !== 128 || req_ready !== 1'b1 || dbg_state !== RUN) begin
      n_err++;
      $display("FAIL init_len: cycles=%0d req_ready=%b state=%0d, required 128 1 1",
               cyc, req_ready, dbg_state);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_write, init_done, csb0, web0, addr0, din0}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 7'h0, 32'h0}) begin
      n_err++;
      $display("FAIL %s: rdy=%b rv=%b rd=%h rw=%b done=%b csb=%b web=%b a=%h din=%h, required 0 0 0 0 0 1 1 0 0",
               tag, req_ready, rsp_valid, rsp_rdata, rsp_write, init_done, csb0, web0, addr0, din0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst0 = 1'b1;
    repeat (3) @(posedge clk0);
    #1 check_reset_values("reset_values");
    rst0 = 1'b0;
    wait_init();
  endtask

  task automatic test_zero_fill_back_to_back();
    int start = cyc_cnt;
    for (int i = 0; i < 128; i++) issue(1'b0, 7'(i), 32'h0, 32'h0);
    n_cmp++;
    if (cyc_cnt - start !== 128) begin
      n_err++;
      $display("FAIL back_to_back: 128 reads took %0d cycles, required 128", cyc_cnt - start);
    end
    drain();
  endtask

  task automatic test_write_then_read();
    issue(1'b1, 7'h05, 32'hDEADBEEF, 32'h0);
    n_cmp++;
    if ({csb0, web0, addr0, din0} !== {1'b0, 1'b0, 7'h05, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL wr_issue: csb0=%b web0=%b addr0=%h din0=%h, required 0 0 05 deadbeef",
               csb0, web0, addr0, din0);
    end
    issue(1'b0, 7'h05, 32'h0, 32'hDEADBEEF);
    n_cmp++;
    if ({csb0, web0, addr0, din0} !== {1'b0, 1'b1, 7'h05, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL rd_issue: csb0=%b web0=%b addr0=%h din0=%h, required 0 1 05 deadbeef",
               csb0, web0, addr0, din0);
    end
    @(negedge clk0);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_e0: rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clk0);
    n_cmp++;
    if (rsp_valid !== WACK) begin
      n_err++; $display("FAIL lat_e1: rsp_valid=%b, required %b", rsp_valid, WACK);
    end
    @(negedge clk0);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL lat_e2: rsp_valid=%b rsp_rdata=%h, required 1 deadbeef", rsp_valid, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc = 0, g = 0;
    logic rdy;
    for (int i = 0; i < 6; i++) issue(1'b1, 7'(10 + i), 32'h100 + i, 32'h0);
    drain();
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(10 + acc);
      @(negedge clk0); rdy = req_ready;
      @(posedge clk0); #1;
      if (rdy) begin exp_q.push_back({1'b0, 32'h100 + acc}); acc++; end
    end
    n_cmp++;
    if (acc !== 4 || req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h100) begin
      n_err++;
      $display("FAIL backpressure: accepted=%0d req_ready=%b rsp_valid=%b head=%h, required 4 0 1 100",
               acc, req_ready, rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    while (acc < 6 && g < 50) begin
      req_valid = 1'b1; req_addr = 7'(10 + acc);
      @(negedge clk0); rdy = req_ready;
      @(posedge clk0); #1; g++;
      if (rdy) begin exp_q.push_back({1'b0, 32'h100 + acc}); acc++; end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (acc !== 6) begin
      n_err++; $display("FAIL bp_resume: accepted=%0d, required 6", acc);
    end
    drain();
  endtask

  task automatic test_top_address();
    issue(1'b1, 7'h7F, 32'h12345678, 32'h0);
    n_cmp++;
    if (addr0 !== 7'h7F) begin
      n_err++; $display("FAIL addr_top: addr0=%h, required 7f", addr0);
    end
    issue(1'b0, 7'h7F, 32'h0, 32'h12345678);
    issue(1'b0, 7'h00, 32'h0, 32'h00000000);
    drain();
  endtask

  task automatic test_reset_mid_init();
    rst0 = 1'b1;
    @(posedge clk0); #1 rst0 = 1'b0;
    repeat (50) @(posedge clk0);
    #1 rst0 = 1'b1;
    #1 check_reset_values("reset_mid_init");
    @(posedge clk0); #1 rst0 = 1'b0;
    wait_init();
  endtask

  task automatic test_reset_mid_burst();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 7'h05, 32'h0, 32'hDEADBEEF);
    @(posedge clk0); #1;
    rst0 = 1'b1;
    exp_q.delete();
    #1 check_reset_values("reset_mid_burst");
    @(posedge clk0); #1 rst0 = 1'b0;
    wait_init();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk0);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL stale_rsp: rsp_valid=%b, required 0", rsp_valid);
      end
    end
    @(posedge clk0); #1;
    issue(1'b0, 7'h05, 32'h0, 32'h0);
    drain();
  endtask

`ifdef SRAM_CTRL_WACK_EN
  task automatic test_wack();
    issue(1'b1, 7'h20, 32'hCAFE0001, 32'h0);
    issue(1'b0, 7'h20, 32'h0, 32'hCAFE0001);
    issue(1'b1, 7'h21, 32'hCAFE0002, 32'h0);
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_fill_back_to_back();
    test_write_then_read();
    test_backpressure();
    test_top_address();
`ifdef SRAM_CTRL_WACK_EN
    test_wack();
`endif
    test_reset_mid_init();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_32x128_ctrl.md
# sram_32x128_ctrl

Request-side controller that sits directly upstream of the 32x128 single-port SRAM macro and drives its port 0 (csb0/web0/addr0/din0), capturing dout0. It converts a valid/ready request stream into macro accesses, returns read data on a backpressurable response stream, and zero-fills the array after reset. All macro inputs come straight from flops, so the macro samples stable values on the posedge after issue.

## Interface
- DATA_WIDTH, 32, word width; must match the macro.
- ADDR_WIDTH, 7, address width; RAM depth is 1<<ADDR_WIDTH.
- RSP_DEPTH, 4, response FIFO entries; minimum 2.
- clk0  in  1  clock; macro shares it.
- rst0  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready at posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for write acks.
- rsp_write  out  1  response is a write ack (only with SRAM_CTRL_WACK_EN; else tied 0).
- init_done  out  1  zero-fill complete.
- csb0, web0  out  1  to macro, active-low select / write.
- addr0  out  ADDR_WIDTH  to macro.
- din0  out  DATA_WIDTH  to macro.
- dout0  in  DATA_WIDTH  from macro.

## Operation
- FSM states: INIT, RUN. Reset enters INIT with init counter 0.
- INIT: each cycle issues write of 0 to address = counter; counter increments. After address RAM_DEPTH-1 is issued, next state RUN and init_done=1. req_ready=0 throughout INIT.
- RUN: req_ready = (inflight_reads + fifo_count + inflight_wacks < RSP_DEPTH). Reads always need a slot; writes need one only with WACK enabled.
- Accepted request loads the issue flops: csb0=0, web0=~req_we, addr0, din0 (din0 loaded only on writes; holds otherwise). No accept: csb0=1, web0=1; addr0/din0 hold.
- Read pipeline: tag bit travels issue -> macro stage -> capture; dout0 captured into FIFO at the posedge two cycles after acceptance.
- Response FIFO: RSP_DEPTH entries, first-word output; pops on rsp_valid&&rsp_ready. Push and pop in same cycle allowed, count unchanged. Never overflows by construction; overflow is an assertion failure.
- Back-to-back requests at one per cycle sustained while rsp_ready=1.
- Address wrap: none; addr0 is exactly req_addr; 127 is a legal final address.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_write 0, init_done 0, csb0 1, web0 1, addr0 0, din0 0.
- Accept at edge E -> macro samples at E+1 -> dout0 valid after negedge of cycle E+1 -> captured at E+2 -> rsp_valid high in cycle after E+2 (read latency 2 edges, 0 added if FIFO empty).
- Write at E reaches the array at the negedge after E+1; a read accepted at E+1 to the same address returns the new data.
- INIT takes exactly RAM_DEPTH cycles from reset deassertion; first accept possible at edge RAM_DEPTH+1.
- Reset asserted mid-operation: all flops to reset values immediately, in-flight reads and FIFO contents discarded, INIT restarts from address 0.

## Configuration
- SRAM_CTRL_WACK_EN defined: each accepted write produces one response with rsp_write=1, rsp_rdata=0, ordered with reads, latency identical to reads. INIT writes never ack.
- Undefined: writes produce no response, consume no FIFO slot; rsp_write tied 0.

## Structure
- Package sram_ctrl_pkg: DATA_WIDTH/ADDR_WIDTH defaults, FSM state enum (INIT, RUN), response entry struct (rdata, write flag).
- One sub-module: sram_ctrl_rsp_fifo (parameterised depth, count output, synchronous push/pop, async reset).

## Test plan
- Reset release -> init_done rises after 128 cycles; reading all 128 addresses returns 0x00000000.
- Write 0xDEADBEEF to 0x05, next cycle read 0x05 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 edges after read accept.
- Hold rsp_ready=0, issue 6 reads -> exactly 4 accepted, req_ready low; release rsp_ready -> 4 responses in order, then remaining reads accepted.
- Write 0x12345678 to 0x7F, read 0x7F and 0x00 -> 0x12345678 then 0x00000000; no wrap artefacts.
- Assert rst0 mid-INIT (cycle 50) and mid-read burst -> outputs at reset values immediately, no stale rsp_valid, INIT restarts at address 0.
- With SRAM_CTRL_WACK_EN: interleave write/read/write -> three responses, rsp_write = 1,0,1 in order.
